upcount_mod: RTL
================

UPCOUNT_MOD -- requirements
Module: upcount_mod

Interface
REQ-001 Parameter: CNT_W, default 5, width of count, preset_val and limit.
REQ-002 Parameter: WRAP_W, default 8, width of the wrap counter.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: preset  input  1  synchronous load strobe.
REQ-006 Port: preset_val  input  CNT_W  value loaded into count on preset.
REQ-007 Port: limit  input  CNT_W  terminal value for modulo mode; captured on preset.
REQ-008 Port: mode  input  1  0 = binary (modulo 2^CNT_W), 1 = modulo (limit_q+1).
REQ-009 Port: en  input  1  count enable.
REQ-010 Port: count  output  CNT_W  registered counter value.
REQ-011 Port: tc  output  1  combinational decode, count at the terminal value.
REQ-012 Port: wrap  output  1  registered one-cycle pulse following a wrap.
REQ-013 Port: wrap_cnt  output  WRAP_W  registered, saturating count of wraps.

Function
REQ-014 Terminal value term SHALL be 2^CNT_W-1 when mode=0, and limit_q when mode=1.
REQ-015 limit_q SHALL be an internal register loaded from limit only in preset cycles; changes to limit at other times SHALL have no effect.
REQ-016 Priority per edge SHALL be reset > preset > en > hold.
REQ-017 On preset: count<=preset_val, limit_q<=limit, wrap<=0; wrap_cnt unchanged.
REQ-018 On en with no preset and count<term: count<=count+1, wrap<=0.
REQ-019 On en with no preset and count>=term: count<=0, wrap<=1, and wrap_cnt<=wrap_cnt+1, saturating at 2^WRAP_W-1.
REQ-020 The ">=" compare SHALL also cover mode=1 with count>limit_q (for example after a preset of preset_val>limit), which wraps to 0 on the next enabled edge.
REQ-021 On en=0 with no preset: count, limit_q and wrap_cnt SHALL hold, and wrap<=0.
REQ-022 tc SHALL be (count==term) in mode=0, and (count>=limit_q) in mode=1, independent of en.
REQ-023 For mode=1 with limit_q=0, count SHALL stay 0 and wrap SHALL be 1 on every enabled edge.
REQ-024 A mode change SHALL take effect on the next edge, using the count value current at that edge.
REQ-025 The latency from an enabled edge to the updated count SHALL be 1 cycle, and wrap SHALL be high in the same cycle that count shows 0 after a wrap.

Reset
REQ-026 When reset=1 at an edge: count<=0, limit_q<=2^CNT_W-1, wrap<=0, wrap_cnt<=0.
REQ-027 Reset SHALL override preset and en in the same cycle.
REQ-028 Asserting reset mid-run SHALL lose the previous count and wrap_cnt.
REQ-029 With no reset asserted, outputs before the first edge are X; the bench SHALL apply reset at time 0.

Structure
REQ-030 Package upcount_pkg SHALL hold CNT_W and WRAP_W defaults and the MODE_BIN=1'b0 and MODE_MOD=1'b1 constants.
REQ-031 The saturating wrap counter SHALL be one sub-module, sat_counter (params WIDTH; ports clk, reset, inc, value).
REQ-032 All other logic SHALL stay in upcount_mod, with no other sub-modules.
REQ-033 The RTL SHALL have no latches and no asynchronous logic.

Verification
REQ-034 Reset check: reset=1 for 1 edge, then mode=0, en=1 for 33 edges -> count runs 0..31 then 0,1; tc=1 only at 31; wrap=1 only when count returns to 0; wrap_cnt=1.
REQ-035 Modulo check: preset=1 with preset_val=0 and limit=5, then mode=1, en=1 -> count 0,1,2,3,4,5,0,...; wrap pulses every 6 edges; tc=1 at 5.
REQ-036 Preset above limit: preset_val=20, limit=5, mode=1, en=1 -> next edge count=0 and wrap=1; tc=1 while count=20.
REQ-037 Simultaneous events: preset=1 and en=1 with preset_val=9 -> count=9, no increment; reset=1 with preset=1 -> count=0 and limit_q=31.
REQ-038 Hold and mode switch: en=0 at count=7 for 4 edges -> count stays 7 and wrap=0; mode changed 1->0 at count=5 with limit_q=5 -> count continues 6,7,... up to 31.
REQ-039 Saturation: WRAP_W=2, mode=1, limit=0, en=1 for 6 edges -> wrap_cnt 1,2,3,3,3,3; wrap stays 1.

Source files
------------

// File: rtl/upcount_pkg.sv
// upcount_pkg: shared defaults and mode encodings for upcount_mod.
//   CNT_W_DEF  : default width of count/preset_val/limit
//   WRAP_W_DEF : default width of the saturating wrap counter
//   MODE_BIN   : binary counting, modulo 2^CNT_W
//   MODE_MOD   : modulo counting, modulo limit_q+1
package upcount_pkg;
    localparam int CNT_W_DEF  = 5;
    localparam int WRAP_W_DEF = 8;
    localparam logic MODE_BIN = 1'b0;
    localparam logic MODE_MOD = 1'b1;
endpackage

// File: rtl/upcount_sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones maximum.
//   clk   : rising-edge clock
//   reset : synchronous active-high clear
//   inc   : advance by one unless already saturated
//   value : current count
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);
    always_ff @(posedge clk)
        value <= reset ? '0 : (inc && value != '1) ? value + WIDTH'(1) : value;
endmodule

// File: rtl/upcount_mod.sv
// upcount_mod: presettable up-counter with binary/modulo modes and wrap tracking.
//   clk        : rising-edge clock
//   reset      : synchronous active-high reset
//   preset     : load count from preset_val and capture limit
//   preset_val : value loaded into count on preset
//   limit      : terminal value for modulo mode, captured on preset
//   mode       : MODE_BIN or MODE_MOD
//   en         : count enable
//   count      : registered counter value
//   tc         : count at (or beyond) the terminal value
//   wrap       : one-cycle pulse coinciding with count returning to 0
//   wrap_cnt   : saturating number of wraps since reset
module upcount_mod
    import upcount_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WRAP_W = WRAP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              preset,
    input  logic [CNT_W-1:0]  preset_val,
    input  logic [CNT_W-1:0]  limit,
    input  logic              mode,
    input  logic              en,
    output logic [CNT_W-1:0]  count,
    output logic              tc,
    output logic              wrap,
    output logic [WRAP_W-1:0] wrap_cnt
);
    logic [CNT_W-1:0] limit_q;
    logic [CNT_W-1:0] term;
    // >= rather than == so a preset above limit_q still wraps; in binary mode
    // term is all ones, so this reduces to equality.
    assign term = (mode == MODE_MOD) ? limit_q : '1;
    assign tc   = count >= term;
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            limit_q <= '1;
            wrap    <= 1'b0;
        end else if (preset) begin
            count   <= preset_val;
            limit_q <= limit;
            wrap    <= 1'b0;
        end else begin
            count <= en ? (tc ? '0 : count + CNT_W'(1)) : count;
            wrap  <= en && tc;
        end
    end
    sat_counter #(.WIDTH(WRAP_W)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!preset && en && tc),
        .value (wrap_cnt)
    );
endmodule
